lpif_txrx_asym_gearbox: RTL and testbench
=========================================

# lpif_txrx_asym_gearbox

Parametrised LPIF-to-logic-link gearbox for asymmetric AIB configurations. It replaces a fixed 1:1 field-packing wrapper with a registered serialiser and deserialiser. On transmit, one LPIF downstream beat is packed into a flat word and sent over RATIO narrower FIFO words, each tagged with a phase marker. On receive, those words are realigned into one LPIF upstream beat. It sits between the LPIF adapter and the logic-link TX/RX FIFOs.

## Interface
Parameters:
- LPIF_DATA_WIDTH, 128: LPIF data width; a multiple of 16. CRC width CW = LPIF_DATA_WIDTH/16.
- RATIO, 2: FIFO words per LPIF beat. Legal values: 1, 2, 4.

Ports:
- clk_wr  in  1  sole clock.
- rst_wr_n  in  1  synchronous active-low reset.
- dstrm_state  in  4  downstream LPIF state.
- dstrm_protid  in  2  downstream protocol id.
- dstrm_data  in  LPIF_DATA_WIDTH  downstream data.
- dstrm_dvalid  in  1  downstream data valid flag.
- dstrm_crc  in  CW  downstream CRC.
- dstrm_crc_valid  in  1  downstream CRC valid flag.
- dstrm_valid  in  1  downstream beat present; also the handshake request.
- dstrm_ready  out  1  gearbox accepts the beat this cycle.
- txfifo_downstream_data  out  LL_W  phase word to TX FIFO.
- txfifo_downstream_vld  out  1  phase word valid.
- txfifo_downstream_ready  in  1  TX FIFO accepts the word.
- rxfifo_upstream_data  in  LL_W  phase word from RX FIFO.
- rxfifo_upstream_vld  in  1  RX word valid; no backpressure.
- ustrm_state / ustrm_protid / ustrm_data / ustrm_dvalid / ustrm_crc / ustrm_crc_valid / ustrm_valid  out  mirror of dstrm widths  registered upstream beat.
- ustrm_beat_vld  out  1  one-cycle pulse when the ustrm_* registers update.
- rx_align_err  out  1  one-cycle pulse on a marker sequence violation.

Widths:
- TOTAL = 9 + LPIF_DATA_WIDTH + CW (145 at the defaults).
- PW = ceil(TOTAL/RATIO).
- LL_W = PW + 1, or PW + 2 with parity compiled in.

## Operation
- Packed word layout, LSB first: state[3:0], protid, data, dvalid, crc, crc_valid, valid. Zero-padded to RATIO*PW bits.
- Phase word k: bits [PW-1:0] carry packed[k*PW +: PW]. Bit PW is the marker: 1 only when k = 0. Bit PW+1 is parity (see Configuration).

TX state machine, states IDLE and SEND, with phase counter tx_ph:
- dstrm_ready = rst_wr_n & (IDLE | (SEND & tx_ph==RATIO-1 & txfifo_downstream_ready)).
- A beat is accepted when dstrm_valid & dstrm_ready. On acceptance: capture into the holding register, set tx_ph=0, go to SEND.
- In SEND, txfifo_downstream_vld=1. tx_ph advances only when txfifo_downstream_ready=1.
- When the last phase is accepted: reload if a new beat is accepted in that same cycle (back-to-back); otherwise return to IDLE.
- In IDLE, txfifo_downstream_vld=0 and the data output holds its last value.

RX, with phase counter rx_ph (0 = expecting marker). Each case below applies to a word with rxfifo_upstream_vld=1:
- Marker=1 and rx_ph=0: store phase 0; rx_ph=1.
- Marker=1 and rx_ph≠0: pulse rx_align_err, discard the partial beat, store this word as phase 0, rx_ph=1.
- Marker=0 and rx_ph=0: pulse rx_align_err, drop the word.
- Marker=0 and rx_ph≠0: store the word; advance rx_ph.
- When the last phase is stored: load all ustrm_* from the assembled word, pulse ustrm_beat_vld, rx_ph=0.
- RATIO=1: every marked word completes a beat.

Reset:
- State goes to IDLE; tx_ph=0, rx_ph=0.
- All outputs are 0, except dstrm_ready, which is 0 during reset and 1 in the first cycle after reset deasserts.
- A reset mid-beat discards partial TX and RX beats; no partial word is emitted afterwards.

## Timing
- TX: beat accepted in cycle N; phase 0 is presented in cycle N+1. With ready held high, phase k is presented in cycle N+1+k.
- Sustained TX throughput is one beat per RATIO cycles, with no bubble between beats.
- RX: last phase valid in cycle M; ustrm_* and ustrm_beat_vld update in cycle M+1.
- rx_align_err is asserted in the cycle after the offending word.
- All outputs are registered except dstrm_ready and txfifo_downstream_vld, which are decoded from registered state.

## Configuration
- LPIF_GEARBOX_PARITY_EN defined:
  - TX appends an even-parity bit over bits [PW:0] at bit PW+1.
  - RX checks parity on every valid word. On a mismatch it pulses rx_align_err, discards the partial beat, and sets rx_ph=0.
- LPIF_GEARBOX_PARITY_EN undefined: LL_W = PW+1 and no parity logic exists.

## Structure
- Package lpif_gearbox_pkg holds:
  - the TOTAL/PW/LL_W width functions;
  - the packed-field offset localparams;
  - the TX state enum {IDLE, SEND}.
- One sub-module, lpif_gearbox_rx_align, contains the RX counter, marker/parity checking and the assembly register.
- The TX path lives in the top module.

## Test plan
- RATIO=2, defaults, ready held high. Send beat data=128'hA5..A5, state=4'h3. Expect two words: marker 1 then 0. ustrm_data=128'hA5..A5 four cycles after acceptance in loopback.
- RATIO=4, back-to-back beats with valid held high. Expect dstrm_ready high every 4th cycle and txfifo_downstream_vld continuously high.
- RATIO=2, deassert txfifo_downstream_ready for 3 cycles at phase 1. Expect the word held stable and dstrm_ready low until phase 1 is accepted.
- RX injects marker=1, marker=1, marker=0. Expect one rx_align_err pulse and one beat built from the 2nd and 3rd words.
- Assert rst_wr_n low during TX phase 1. Expect all outputs 0, no resumed phase, and dstrm_ready=1 one cycle after release.
- With LPIF_GEARBOX_PARITY_EN defined, flip one data bit on RX. Expect an rx_align_err pulse and no ustrm_beat_vld.

Source files
------------

// File: rtl/lpif_gearbox_pkg.sv
// Width helpers, packed-field offsets and TX state type for the LPIF gearbox.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Packed beat layout, LSB first: state[3:0], protid[1:0], data, dvalid, crc, crc_valid, valid.
// LPIF_GEARBOX_PARITY_EN adds one even-parity bit to every link word.
package lpif_gearbox_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} tx_state_e;

  // Offsets of the fields that do not depend on the data width.
  localparam int OFF_STATE  = 0;
  localparam int OFF_PROTID = 4;
  localparam int OFF_DATA   = 6;

  function automatic int crc_w(input int dw);
    return dw / 16;
  endfunction

  function automatic int total_w(input int dw);
    return 9 + dw + crc_w(dw);
  endfunction

  function automatic int phase_w(input int dw, input int ratio);
    return (total_w(dw) + ratio - 1) / ratio;
  endfunction

  function automatic int ll_w(input int dw, input int ratio);
`ifdef LPIF_GEARBOX_PARITY_EN
    return phase_w(dw, ratio) + 2;
`else
    return phase_w(dw, ratio) + 1;
`endif
  endfunction

  function automatic int ph_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Offsets of the fields that sit above the data bus.
  function automatic int off_dvalid(input int dw);
    return OFF_DATA + dw;
  endfunction

  function automatic int off_crc(input int dw);
    return off_dvalid(dw) + 1;
  endfunction

  function automatic int off_crc_valid(input int dw);
    return off_crc(dw) + crc_w(dw);
  endfunction

  function automatic int off_valid(input int dw);
    return off_crc_valid(dw) + 1;
  endfunction

endpackage

// File: rtl/lpif_gearbox_rx_align.sv
// RX realignment: collects RATIO marker-tagged link words into one packed beat.
// Latency: beat/beat_vld register one cycle after the last phase word; align_err one cycle after the bad word.
// Backpressure: none; every valid word is consumed in its cycle.
// Ports: clk/rst_n (sync active-low), word_vld/word (link word in),
//        beat/beat_vld (assembled beat + pulse), align_err (sequence or parity violation pulse).
// LPIF_GEARBOX_PARITY_EN: checks even parity over the whole word and drops the partial beat on error.
module lpif_gearbox_rx_align
  import lpif_gearbox_pkg::*;
#(
  parameter int PW    = 73,
  parameter int RATIO = 2,
  parameter int LL_W  = 74
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  word_vld,
  input  logic [LL_W-1:0]       word,
  output logic [RATIO*PW-1:0]   beat,
  output logic                  beat_vld,
  output logic                  align_err
);

  localparam int PKW = RATIO * PW;
  localparam int PHW = ph_cnt_w(RATIO);
  localparam logic [PHW-1:0] PH_LAST = PHW'(RATIO - 1);

  logic [PHW-1:0] rx_ph;
  logic [PHW-1:0] eff_ph;
  logic [PKW-1:0] asm_q;
  logic [PKW-1:0] asm_nxt;
  logic           marker;
  logic           par_ok;
  logic           seq_err;
  logic           take;
  logic           last;

  always_comb begin
    marker = word[PW];
`ifdef LPIF_GEARBOX_PARITY_EN
    par_ok = ~^word;
`else
    par_ok = 1'b1;
`endif
    // A marker always restarts assembly at phase 0, even mid-beat.
    eff_ph  = marker ? '0 : rx_ph;
    seq_err = marker ? (rx_ph != '0) : (rx_ph == '0);
    take    = word_vld & par_ok & (marker | (rx_ph != '0));
    last    = (eff_ph == PH_LAST);
    asm_nxt = asm_q;
    asm_nxt[int'(eff_ph) * PW +: PW] = word[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ph     <= '0;
      asm_q     <= '0;
      beat      <= '0;
      beat_vld  <= 1'b0;
      align_err <= 1'b0;
    end else begin
      beat_vld  <= 1'b0;
      align_err <= word_vld & (seq_err | ~par_ok);
      if (word_vld & ~par_ok) begin
        rx_ph <= '0;
      end else if (take) begin
        asm_q <= asm_nxt;
        if (last) begin
          beat     <= asm_nxt;
          beat_vld <= 1'b1;
          rx_ph    <= '0;
        end else begin
          rx_ph <= eff_ph + PHW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/lpif_txrx_asym_gearbox.sv
// LPIF <-> logic-link gearbox: serialises one LPIF beat into RATIO link words and reassembles the reverse direction.
// Latency: TX phase 0 one cycle after acceptance; RX beat one cycle after its last phase word.
// Backpressure: TX words stall on txfifo_downstream_ready and dstrm_ready stays low until the last phase leaves; RX has none.
// Ports: clk_wr/rst_wr_n (sync active-low), dstrm_* (LPIF beat in, valid/ready), txfifo_downstream_* (link word out),
//        rxfifo_upstream_* (link word in), ustrm_* + ustrm_beat_vld (registered beat out), rx_align_err.
// LPIF_GEARBOX_PARITY_EN: adds an even-parity bit at position PW+1 of every link word.
module lpif_txrx_asym_gearbox
  import lpif_gearbox_pkg::*;
#(
  parameter  int LPIF_DATA_WIDTH = 128,
  parameter  int RATIO           = 2,
  localparam int CW              = LPIF_DATA_WIDTH / 16,
  localparam int PW              = phase_w(LPIF_DATA_WIDTH, RATIO),
  localparam int LL_W            = ll_w(LPIF_DATA_WIDTH, RATIO)
) (
  input  logic                       clk_wr,
  input  logic                       rst_wr_n,
  input  logic [3:0]                 dstrm_state,
  input  logic [1:0]                 dstrm_protid,
  input  logic [LPIF_DATA_WIDTH-1:0] dstrm_data,
  input  logic                       dstrm_dvalid,
  input  logic [CW-1:0]              dstrm_crc,
  input  logic                       dstrm_crc_valid,
  input  logic                       dstrm_valid,
  output logic                       dstrm_ready,
  output logic [LL_W-1:0]            txfifo_downstream_data,
  output logic                       txfifo_downstream_vld,
  input  logic                       txfifo_downstream_ready,
  input  logic [LL_W-1:0]            rxfifo_upstream_data,
  input  logic                       rxfifo_upstream_vld,
  output logic [3:0]                 ustrm_state,
  output logic [1:0]                 ustrm_protid,
  output logic [LPIF_DATA_WIDTH-1:0] ustrm_data,
  output logic                       ustrm_dvalid,
  output logic [CW-1:0]              ustrm_crc,
  output logic                       ustrm_crc_valid,
  output logic                       ustrm_valid,
  output logic                       ustrm_beat_vld,
  output logic                       rx_align_err
);

  localparam int TOTAL = total_w(LPIF_DATA_WIDTH);
  localparam int PKW   = RATIO * PW;
  localparam int PHW   = ph_cnt_w(RATIO);
  localparam int O_DV  = off_dvalid(LPIF_DATA_WIDTH);
  localparam int O_CRC = off_crc(LPIF_DATA_WIDTH);
  localparam int O_CV  = off_crc_valid(LPIF_DATA_WIDTH);
  localparam int O_V   = off_valid(LPIF_DATA_WIDTH);
  localparam logic [PHW-1:0] PH_LAST = PHW'(RATIO - 1);

  tx_state_e      tx_state;
  tx_state_e      tx_state_nxt;
  logic [PHW-1:0] tx_ph;
  logic [PKW-1:0] tx_hold;
  logic [PKW-1:0] din_packed;
  logic [PKW-1:0] rx_beat;
  logic           tx_last;
  logic           tx_adv;
  logic           accept;

  // Link word for phase ph: payload slice, marker on phase 0, optional parity on top.
  function automatic logic [LL_W-1:0] phase_word(input logic [PKW-1:0] pk, input logic [PHW-1:0] ph);
    logic [PW:0] w;
    w = {ph == '0, pk[int'(ph) * PW +: PW]};
`ifdef LPIF_GEARBOX_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  always_comb begin
    din_packed                       = '0;
    din_packed[OFF_STATE +: 4]       = dstrm_state;
    din_packed[OFF_PROTID +: 2]      = dstrm_protid;
    din_packed[OFF_DATA +: LPIF_DATA_WIDTH] = dstrm_data;
    din_packed[O_DV]                 = dstrm_dvalid;
    din_packed[O_CRC +: CW]          = dstrm_crc;
    din_packed[O_CV]                 = dstrm_crc_valid;
    din_packed[O_V]                  = dstrm_valid;
  end

  assign tx_last = (tx_ph == PH_LAST);
  // Ready is open in IDLE, or in the cycle the final phase drains so beats go back-to-back.
  assign dstrm_ready = rst_wr_n & ((tx_state == IDLE) |
                                   ((tx_state == SEND) & tx_last & txfifo_downstream_ready));
  assign accept = dstrm_valid & dstrm_ready;
  assign txfifo_downstream_vld = (tx_state == SEND);
  assign tx_adv = (tx_state == SEND) & txfifo_downstream_ready & ~tx_last;

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      IDLE: if (accept) tx_state_nxt = SEND;
      SEND: if (tx_last & txfifo_downstream_ready) tx_state_nxt = accept ? SEND : IDLE;
      default: tx_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) tx_state <= IDLE;
    else           tx_state <= tx_state_nxt;
  end

  // Output word is registered; the next phase is loaded as the current one is taken.
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      tx_ph                  <= '0;
      tx_hold                <= '0;
      txfifo_downstream_data <= '0;
    end else if (accept) begin
      tx_hold                <= din_packed;
      tx_ph                  <= '0;
      txfifo_downstream_data <= phase_word(din_packed, '0);
    end else if (tx_adv) begin
      tx_ph                  <= tx_ph + PHW'(1);
      txfifo_downstream_data <= phase_word(tx_hold, tx_ph + PHW'(1));
    end
  end

  lpif_gearbox_rx_align #(
    .PW    (PW),
    .RATIO (RATIO),
    .LL_W  (LL_W)
  ) u_rx_align (
    .clk       (clk_wr),
    .rst_n     (rst_wr_n),
    .word_vld  (rxfifo_upstream_vld),
    .word      (rxfifo_upstream_data),
    .beat      (rx_beat),
    .beat_vld  (ustrm_beat_vld),
    .align_err (rx_align_err)
  );

  assign ustrm_state     = rx_beat[OFF_STATE +: 4];
  assign ustrm_protid    = rx_beat[OFF_PROTID +: 2];
  assign ustrm_data      = rx_beat[OFF_DATA +: LPIF_DATA_WIDTH];
  assign ustrm_dvalid    = rx_beat[O_DV];
  assign ustrm_crc       = rx_beat[O_CRC +: CW];
  assign ustrm_crc_valid = rx_beat[O_CV];
  assign ustrm_valid     = rx_beat[O_V];

  // Zero padding above the last field carries no information.
  if (PKW > TOTAL) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^rx_beat[PKW-1:TOTAL];
  end

endmodule

// File: tb/tb_lpif_txrx_asym_gearbox.sv
module tb_lpif_txrx_asym_gearbox;

  localparam int DW = 128;
  localparam int CW = 8;
`ifdef LPIF_GEARBOX_PARITY_EN
  localparam int LLW2 = 75;
  localparam int LLW4 = 39;
`else
  localparam int LLW2 = 74;
  localparam int LLW4 = 38;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [3:0]      d_state;
  logic [1:0]      d_protid;
  logic [DW-1:0]   d_data;
  logic            d_dvalid;
  logic [CW-1:0]   d_crc;
  logic            d_crcv;
  logic            d2_valid, d4_valid;
  logic            d2_rdy, d4_rdy;
  logic            t2_rdy, t4_rdy;
  logic [LLW2-1:0] t2_dat;
  logic [LLW4-1:0] t4_dat;
  logic            t2_vld, t4_vld;
  logic            loop, inj_vld;
  logic [LLW2-1:0] inj_dat;
  logic            lb_vld;
  logic [LLW2-1:0] lb_dat;
  logic            rx2_vld;
  logic [LLW2-1:0] rx2_dat;
  logic [3:0]      u2_state, u4_state;
  logic [1:0]      u2_protid, u4_protid;
  logic [DW-1:0]   u2_data, u4_data;
  logic            u2_dvalid, u4_dvalid, u2_crcv, u4_crcv, u2_valid, u4_valid;
  logic [CW-1:0]   u2_crc, u4_crc;
  logic            u2_bvld, u4_bvld, u2_err, u4_err;
  logic [LLW2-1:0] tmp;

  int total = 0;
  int bad   = 0;

  // One-cycle FIFO stand-in between TX and RX of the RATIO=2 instance.
  always @(posedge clk) begin
    if (!rst_n) lb_vld <= 1'b0;
    else        lb_vld <= t2_vld & t2_rdy;
    lb_dat <= t2_dat;
  end
  assign rx2_vld = loop ? lb_vld : inj_vld;
  assign rx2_dat = loop ? lb_dat : inj_dat;

  lpif_txrx_asym_gearbox #(.LPIF_DATA_WIDTH(DW), .RATIO(2)) u2 (
    .clk_wr(clk), .rst_wr_n(rst_n),
    .dstrm_state(d_state), .dstrm_protid(d_protid), .dstrm_data(d_data), .dstrm_dvalid(d_dvalid),
    .dstrm_crc(d_crc), .dstrm_crc_valid(d_crcv), .dstrm_valid(d2_valid), .dstrm_ready(d2_rdy),
    .txfifo_downstream_data(t2_dat), .txfifo_downstream_vld(t2_vld), .txfifo_downstream_ready(t2_rdy),
    .rxfifo_upstream_data(rx2_dat), .rxfifo_upstream_vld(rx2_vld),
    .ustrm_state(u2_state), .ustrm_protid(u2_protid), .ustrm_data(u2_data), .ustrm_dvalid(u2_dvalid),
    .ustrm_crc(u2_crc), .ustrm_crc_valid(u2_crcv), .ustrm_valid(u2_valid),
    .ustrm_beat_vld(u2_bvld), .rx_align_err(u2_err));

  lpif_txrx_asym_gearbox #(.LPIF_DATA_WIDTH(DW), .RATIO(4)) u4 (
    .clk_wr(clk), .rst_wr_n(rst_n),
    .dstrm_state(d_state), .dstrm_protid(d_protid), .dstrm_data(d_data), .dstrm_dvalid(d_dvalid),
    .dstrm_crc(d_crc), .dstrm_crc_valid(d_crcv), .dstrm_valid(d4_valid), .dstrm_ready(d4_rdy),
    .txfifo_downstream_data(t4_dat), .txfifo_downstream_vld(t4_vld), .txfifo_downstream_ready(t4_rdy),
    .rxfifo_upstream_data('0), .rxfifo_upstream_vld(1'b0),
    .ustrm_state(u4_state), .ustrm_protid(u4_protid), .ustrm_data(u4_data), .ustrm_dvalid(u4_dvalid),
    .ustrm_crc(u4_crc), .ustrm_crc_valid(u4_crcv), .ustrm_valid(u4_valid),
    .ustrm_beat_vld(u4_bvld), .rx_align_err(u4_err));

  // Expected RATIO=2 link word, built from the field layout (valid bit always 1 for a sent beat).
  function automatic logic [LLW2-1:0] mk2(input bit ph, input logic [3:0] st, input logic [1:0] pid,
                                          input logic [DW-1:0] dat, input logic dv,
                                          input logic [CW-1:0] crc, input logic crcv);
    logic [145:0] p;
    logic [73:0]  w;
    p = {1'b0, 1'b1, crcv, crc, dv, dat, pid, st};
    w = ph ? {1'b0, p[145:73]} : {1'b1, p[72:0]};
`ifdef LPIF_GEARBOX_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [3:0] st, input logic [1:0] pid, input logic [DW-1:0] dat,
                          input logic dv, input logic [CW-1:0] crc, input logic crcv);
    d_state = st; d_protid = pid; d_data = dat; d_dvalid = dv; d_crc = crc; d_crcv = crcv;
  endtask

  localparam logic [DW-1:0] DA = {4{32'hA5A5A5A5}};
  localparam logic [DW-1:0] DB = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [DW-1:0] DC = 128'hDEADBEEF_00C0FFEE_13579BDF_2468ACE0;
  localparam logic [DW-1:0] DD = 128'hCAFEF00D_11223344_55667788_99AABBCC;
  localparam logic [DW-1:0] DX = {4{32'h11111111}};

  initial begin
    rst_n = 1'b0; d2_valid = 1'b0; d4_valid = 1'b0; t2_rdy = 1'b1; t4_rdy = 1'b1;
    loop = 1'b1; inj_vld = 1'b0; inj_dat = '0;
    set_beat(4'h0, 2'h0, '0, 1'b0, '0, 1'b0);
    repeat (3) tick();

    // Reset state
    chk("rst_ready", d2_rdy, 0);
    chk("rst_txvld", t2_vld, 0);
    chk("rst_txdat", t2_dat, 0);
    chk("rst_udata", u2_data, 0);
    chk("rst_bvld", u2_bvld, 0);
    chk("rst_err", u2_err, 0);
    rst_n = 1'b1; #1;
    chk("rel_ready2", d2_rdy, 1);
    chk("rel_ready4", d4_rdy, 1);

    // Single beat, loopback through one-cycle FIFO
    set_beat(4'h3, 2'h0, DA, 1'b1, 8'h00, 1'b0);
    d2_valid = 1'b1;
    tick();  // N+1
    d2_valid = 1'b0;
    chk("t1_ph0_vld", t2_vld, 1);
    chk("t1_ph0_dat", t2_dat, mk2(0, 4'h3, 2'h0, DA, 1'b1, 8'h00, 1'b0));
    chk("t1_ph0_rdy", d2_rdy, 0);
    tick();  // N+2
    chk("t1_ph1_dat", t2_dat, mk2(1, 4'h3, 2'h0, DA, 1'b1, 8'h00, 1'b0));
    chk("t1_ph1_rdy", d2_rdy, 1);
    tick();  // N+3
    chk("t1_idle_vld", t2_vld, 0);
    chk("t1_idle_hold", t2_dat, mk2(1, 4'h3, 2'h0, DA, 1'b1, 8'h00, 1'b0));
    chk("t1_bvld_early", u2_bvld, 0);
    tick();  // N+4
    chk("t1_bvld", u2_bvld, 1);
    chk("t1_udata", u2_data, DA);
    chk("t1_ustate", u2_state, 4'h3);
    chk("t1_uvalid", u2_valid, 1);
    chk("t1_udvalid", u2_dvalid, 1);
    tick();
    chk("t1_bvld_pulse", u2_bvld, 0);

    // Backpressure at phase 1 with the next beat waiting
    set_beat(4'h5, 2'h1, DB, 1'b0, 8'h3C, 1'b1);
    d2_valid = 1'b1;
    tick();  // K+1
    chk("t2_ph0_dat", t2_dat, mk2(0, 4'h5, 2'h1, DB, 1'b0, 8'h3C, 1'b1));
    set_beat(4'h7, 2'h3, DC, 1'b1, 8'hC3, 1'b0);
    tick();  // K+2
    t2_rdy = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_dat", t2_dat, mk2(1, 4'h5, 2'h1, DB, 1'b0, 8'h3C, 1'b1));
      chk("t2_stall_rdy", d2_rdy, 0);
      chk("t2_stall_vld", t2_vld, 1);
      tick();
    end
    t2_rdy = 1'b1; #1;  // K+5
    chk("t2_release_rdy", d2_rdy, 1);
    chk("t2_release_dat", t2_dat, mk2(1, 4'h5, 2'h1, DB, 1'b0, 8'h3C, 1'b1));
    tick();  // K+6
    d2_valid = 1'b0;
    chk("t2_b2b_ph0", t2_dat, mk2(0, 4'h7, 2'h3, DC, 1'b1, 8'hC3, 1'b0));
    chk("t2_b2b_vld", t2_vld, 1);
    tick();  // K+7
    chk("t2_c_ph1", t2_dat, mk2(1, 4'h7, 2'h3, DC, 1'b1, 8'hC3, 1'b0));
    chk("t2_b_bvld", u2_bvld, 1);
    chk("t2_b_udata", u2_data, DB);
    chk("t2_b_ucrc", u2_crc, 8'h3C);
    chk("t2_b_uprotid", u2_protid, 2'h1);
    tick();  // K+8
    chk("t2_idle_vld", t2_vld, 0);
    tick();  // K+9
    chk("t2_c_bvld", u2_bvld, 1);
    chk("t2_c_udata", u2_data, DC);
    chk("t2_c_ustate", u2_state, 4'h7);

    // RATIO=4 streaming with valid held high
    d4_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("t3_rdy", d4_rdy, (i % 4) == 0);
      chk("t3_vld", t4_vld, i != 0);
      tick();
    end
    d4_valid = 1'b0;

    // RX injection: marker, marker, plain -> one error then one beat; then a stray plain word
    loop = 1'b0;
    inj_vld = 1'b1;
    inj_dat = mk2(0, 4'h1, 2'h0, DX, 1'b0, 8'h00, 1'b0);
    tick();
    chk("t4_err_first", u2_err, 0);
    inj_dat = mk2(0, 4'hA, 2'h2, DD, 1'b0, 8'h5A, 1'b1);
    tick();
    chk("t4_err_remark", u2_err, 1);
    chk("t4_bvld_remark", u2_bvld, 0);
    inj_dat = mk2(1, 4'hA, 2'h2, DD, 1'b0, 8'h5A, 1'b1);
    tick();
    chk("t4_err_clear", u2_err, 0);
    chk("t4_bvld", u2_bvld, 1);
    chk("t4_udata", u2_data, DD);
    chk("t4_ustate", u2_state, 4'hA);
    chk("t4_uprotid", u2_protid, 2'h2);
    chk("t4_ucrc", u2_crc, 8'h5A);
    chk("t4_ucrcv", u2_crcv, 1);
    chk("t4_udvalid", u2_dvalid, 0);
    tick();
    chk("t4_stray_err", u2_err, 1);
    chk("t4_stray_bvld", u2_bvld, 0);
    inj_vld = 1'b0;
    tick();
    chk("t4_err_idle", u2_err, 0);

    // Reset during TX phase 1
    loop = 1'b1;
    set_beat(4'h9, 2'h1, DB, 1'b1, 8'h77, 1'b1);
    d2_valid = 1'b1;
    tick();
    d2_valid = 1'b0;
    tick();
    chk("t5_pre_ph1", t2_dat, mk2(1, 4'h9, 2'h1, DB, 1'b1, 8'h77, 1'b1));
    rst_n = 1'b0;
    tick();
    chk("t5_rst_vld", t2_vld, 0);
    chk("t5_rst_dat", t2_dat, 0);
    chk("t5_rst_rdy", d2_rdy, 0);
    chk("t5_rst_udata", u2_data, 0);
    chk("t5_rst_ustate", u2_state, 0);
    chk("t5_rst_uvalid", u2_valid, 0);
    rst_n = 1'b1; #1;
    chk("t5_rel_rdy", d2_rdy, 1);
    tick();
    chk("t5_no_resume_vld", t2_vld, 0);
    chk("t5_no_resume_dat", t2_dat, 0);
    tick();
    chk("t5_no_beat", u2_bvld, 0);
    chk("t5_no_err", u2_err, 0);

`ifdef LPIF_GEARBOX_PARITY_EN
    // Parity error on phase 1 drops the beat
    loop = 1'b0;
    inj_vld = 1'b1;
    inj_dat = mk2(0, 4'h2, 2'h1, DC, 1'b1, 8'h11, 1'b0);
    tick();
    chk("t6_err_ph0", u2_err, 0);
    tmp = mk2(1, 4'h2, 2'h1, DC, 1'b1, 8'h11, 1'b0);
    tmp[5] = ~tmp[5];
    inj_dat = tmp;
    tick();
    chk("t6_par_err", u2_err, 1);
    chk("t6_par_bvld", u2_bvld, 0);
    inj_vld = 1'b0;
    tick();
    chk("t6_par_bvld_after", u2_bvld, 0);
    chk("t6_par_err_clear", u2_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
